// File: rtl/cpu_dbus_router_pkg.sv
// Shared types and default address-map constants for the CPU data-bus router.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        TAG_RAM   = 2'd0,
        TAG_IO    = 2'd1,
        TAG_UNMAP = 2'd2
    } bus_tag_t;

    localparam int          DEF_RAM_AW   = 26;
    localparam logic [3:0]  DEF_IO_HI    = 4'hE;
    localparam int          DEF_MAX_OUT  = 4;
    localparam logic [31:0] DEF_UNMAP_RD = 32'h0000_0000;

endpackage

// File: rtl/cpu_dbus_router_if.sv
// Request/response bus used on the CPU side and on both target ports.
interface cpu_dbus_if;
    logic        request;
    logic [31:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output request, addr, write, byte_enable, wdata,
                    input  rdata, ack);
    modport slave  (input  request, addr, write, byte_enable, wdata,
                    output rdata, ack);
endinterface

// File: rtl/cpu_dbus_router_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module bus_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/cpu_dbus_router.sv
// Decodes CPU data requests to RAM / IO / unmapped and returns acks strictly in issue order,
// parking early target responses in per-target buffers.
module cpu_dbus_router
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [3:0]  IO_HI    = DEF_IO_HI,
    parameter int          MAX_OUT  = DEF_MAX_OUT,
    parameter logic [31:0] UNMAP_RD = DEF_UNMAP_RD
) (
    input  logic             clock,
    input  logic             reset,
    cpu_dbus_if.slave        cpud,
    cpu_dbus_if.master       ram,
    cpu_dbus_if.master       io,
    output logic             unmapped_error,
    output logic [31:0]      unmapped_addr,
    output logic             protocol_error
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int NT = 2;

    bus_tag_t         w_in_tag;
    logic             r_req_valid;
    logic [31:0]      r_addr;
    logic             r_write;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    bus_tag_t         r_tag;

    logic             w_oq_push;
    logic             w_oq_pop;
    logic [1:0]       w_oq_dout;
    logic             w_oq_full;
    logic             w_oq_empty;
    logic [CW-1:0]    w_oq_count;
    bus_tag_t         w_head_tag;
    logic             w_head_valid;
    logic             w_retire;
    logic             w_drop;
    logic             w_accept;
    logic [31:0]      w_ret_data;

    logic [NT-1:0]        w_tgt_ack;
    logic [NT-1:0][31:0]  w_tgt_rdata;
    logic [NT-1:0]        w_tgt_sel;
    logic [NT-1:0]        w_tgt_issue;
    logic [NT-1:0]        w_tgt_ready;
    logic [NT-1:0]        w_tgt_stray;
    logic [NT-1:0]        w_tgt_ovf;
    logic [NT-1:0][31:0]  w_tgt_data;

    logic             r_ack;
    logic [31:0]      r_rdata;

    always_comb begin
        w_in_tag = TAG_UNMAP;
        if ((cpud.addr >> RAM_AW) == 32'd0)
            w_in_tag = TAG_RAM;
        else if (cpud.addr[31:28] == IO_HI)
            w_in_tag = TAG_IO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_tag       <= TAG_RAM;
        end else begin
            r_req_valid <= cpud.request;
            if (cpud.request) begin
                r_addr  <= cpud.addr;
                r_write <= cpud.write;
                r_be    <= cpud.byte_enable;
                r_wdata <= cpud.wdata;
                r_tag   <= w_in_tag;
            end
        end
    end

    bus_fifo #(.WIDTH(2), .DEPTH(MAX_OUT)) u_order (
        .i_clk   (clock),
        .i_srst  (reset),
        .i_push  (w_oq_push),
        .i_din   (r_tag),
        .i_pop   (w_oq_pop),
        .o_dout  (w_oq_dout),
        .o_full  (w_oq_full),
        .o_empty (w_oq_empty),
        .o_count (w_oq_count)
    );

    // With an empty order queue the entry being registered this cycle is the head (fast path).
    assign w_head_tag   = w_oq_empty ? r_tag : bus_tag_t'(w_oq_dout);
    assign w_head_valid = (w_oq_count != '0) || r_req_valid;
    assign w_retire     = w_head_valid &&
                          ((w_head_tag == TAG_UNMAP) || (|(w_tgt_sel & w_tgt_ready)));
    assign w_oq_pop     = w_retire && !w_oq_empty;
    assign w_drop       = r_req_valid && w_oq_full && !w_oq_pop;
    assign w_accept     = r_req_valid && !w_drop;
    assign w_oq_push    = w_accept && !(w_retire && w_oq_empty);

    assign w_tgt_ack      = {io.ack, ram.ack};
    assign w_tgt_rdata[0] = ram.rdata;
    assign w_tgt_rdata[1] = io.rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NT; gi++) begin : g_tgt
            localparam bus_tag_t TGT_TAG = (gi == 0) ? TAG_RAM : TAG_IO;

            logic [CW-1:0] r_out_cnt;
            logic          w_ack_ok;
            logic          w_push;
            logic          w_pop;
            logic          w_full;
            logic          w_empty;
            logic [CW-1:0] w_count;
            logic [31:0]   w_dout;

            assign w_tgt_sel[gi]   = w_head_valid && (w_head_tag == TGT_TAG);
            assign w_tgt_issue[gi] = w_accept && (r_tag == TGT_TAG);
            assign w_ack_ok        = w_tgt_ack[gi] && (r_out_cnt != '0);
            assign w_tgt_stray[gi] = w_tgt_ack[gi] && (r_out_cnt == '0);
            assign w_tgt_ready[gi] = (w_count != '0) || w_ack_ok;
            // An ack arriving while its buffer is empty bypasses straight to the CPU.
            assign w_tgt_data[gi]  = w_empty ? w_tgt_rdata[gi] : w_dout;
            assign w_pop           = w_retire && w_tgt_sel[gi] && !w_empty;
            assign w_push          = w_ack_ok && !(w_retire && w_tgt_sel[gi] && w_empty);
            assign w_tgt_ovf[gi]   = w_push && w_full && !w_pop;

            bus_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_buf (
                .i_clk   (clock),
                .i_srst  (reset),
                .i_push  (w_push),
                .i_din   (w_tgt_rdata[gi]),
                .i_pop   (w_pop),
                .o_dout  (w_dout),
                .o_full  (w_full),
                .o_empty (w_empty),
                .o_count (w_count)
            );

            always_ff @(posedge clock) begin
                if (reset)
                    r_out_cnt <= '0;
                else
                    r_out_cnt <= r_out_cnt + CW'(w_tgt_issue[gi]) - CW'(w_ack_ok);
            end
        end
    endgenerate

    always_comb begin
        w_ret_data = UNMAP_RD;
        if (w_head_tag == TAG_RAM)
            w_ret_data = w_tgt_data[0];
        else if (w_head_tag == TAG_IO)
            w_ret_data = w_tgt_data[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack          <= 1'b0;
            r_rdata        <= '0;
            unmapped_error <= 1'b0;
            unmapped_addr  <= '0;
            protocol_error <= 1'b0;
        end else begin
            r_ack <= w_retire;
            if (w_retire)
                r_rdata <= w_ret_data;
            if (r_req_valid && (r_tag == TAG_UNMAP)) begin
                unmapped_error <= 1'b1;
                if (!unmapped_error)
                    unmapped_addr <= r_addr;
            end
            if (w_drop || (|w_tgt_stray) || (|w_tgt_ovf))
                protocol_error <= 1'b1;
        end
    end

    assign cpud.ack    = r_ack;
    assign cpud.rdata  = r_rdata;

    assign ram.request     = w_tgt_issue[0];
    assign ram.addr        = r_addr;
    assign ram.write       = r_write;
    assign ram.byte_enable = r_be;
    assign ram.wdata       = r_wdata;

    assign io.request      = w_tgt_issue[1];
    assign io.addr         = r_addr;
    assign io.write        = r_write;
    assign io.byte_enable  = r_be;
    assign io.wdata        = r_wdata;
endmodule

// File: tb/tb_cpu_dbus_router.sv
// Directed scenarios followed by randomized traffic against an in-order reference model.
module tb_cpu_dbus_router;
    import cpu_bus_pkg::*;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    cpu_dbus_if cpud_bus ();
    cpu_dbus_if ram_bus ();
    cpu_dbus_if io_bus ();

    logic        unmapped_error;
    logic [31:0] unmapped_addr;
    logic        protocol_error;

    cpu_dbus_router dut (
        .clock          (clk),
        .reset          (srst),
        .cpud           (cpud_bus),
        .ram            (ram_bus),
        .io             (io_bus),
        .unmapped_error (unmapped_error),
        .unmapped_addr  (unmapped_addr),
        .protocol_error (protocol_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int ram_req_cnt = 0;
    int io_req_cnt  = 0;
    int ack_cnt     = 0;
    bit auto_mode   = 0;

    typedef struct { int due; logic [31:0] data; } resp_t;
    typedef struct { bus_tag_t tag; logic wr; int seq; } exp_t;

    resp_t       sched [2][$];
    int          last_due [2];
    int          seq_q [2][$];
    exp_t        exp_q [$];
    logic [31:0] seq_addr [1024];
    logic        seq_wr   [1024];
    logic [31:0] seq_data [1024];
    int          outstanding = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bus_tag_t model_tag(input logic [31:0] a);
        if (a < 32'h0400_0000) return TAG_RAM;
        if (a >= 32'hE000_0000 && a <= 32'hEFFF_FFFF) return TAG_IO;
        return TAG_UNMAP;
    endfunction

    task automatic req(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        cpud_bus.request     = 1'b1;
        cpud_bus.addr        = a;
        cpud_bus.write       = w;
        cpud_bus.byte_enable = be;
        cpud_bus.wdata       = d;
    endtask

    task automatic clr();
        cpud_bus.request = 1'b0;
    endtask

    // Advance one clock, sample outputs, and in auto mode act as in-order targets plus scoreboard.
    task automatic cyc();
        logic        t_req;
        logic [31:0] t_addr;
        logic        t_wr;
        exp_t        e;
        int          s;
        int          due;
        resp_t       r;
        @(posedge clk);
        #1;
        cyc_n++;
        ram_req_cnt += int'(ram_bus.request);
        io_req_cnt  += int'(io_bus.request);
        ack_cnt     += int'(cpud_bus.ack);
        if (auto_mode) begin
            if (cpud_bus.ack) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    outstanding--;
                    if (e.tag == TAG_UNMAP)
                        check("rnd_unmap_rdata", cpud_bus.rdata, 32'h0);
                    else if (!e.wr)
                        check("rnd_rdata", cpud_bus.rdata, seq_data[e.seq]);
                end
            end
            for (int t = 0; t < 2; t++) begin
                t_req  = (t == 0) ? ram_bus.request : io_bus.request;
                t_addr = (t == 0) ? ram_bus.addr    : io_bus.addr;
                t_wr   = (t == 0) ? ram_bus.write   : io_bus.write;
                if (t_req) begin
                    if (seq_q[t].size() == 0) begin
                        check("rnd_unexpected_tgt_req", 32'd1, 32'd0);
                    end else begin
                        s = seq_q[t].pop_front();
                        check("rnd_tgt_addr", t_addr, seq_addr[s]);
                        check("rnd_tgt_write", 32'(t_wr), 32'(seq_wr[s]));
                        seq_data[s] = $urandom;
                        due = cyc_n + int'($urandom_range(1, 6));
                        if (due <= last_due[t]) due = last_due[t] + 1;
                        last_due[t] = due;
                        r.due  = due;
                        r.data = seq_data[s];
                        sched[t].push_back(r);
                    end
                end
            end
            for (int t = 0; t < 2; t++) begin
                logic        a;
                logic [31:0] d;
                a = 1'b0;
                d = $urandom;
                if (sched[t].size() > 0 && sched[t][0].due == cyc_n) begin
                    r = sched[t].pop_front();
                    a = 1'b1;
                    d = r.data;
                end
                if (t == 0) begin
                    ram_bus.ack = a; ram_bus.rdata = d;
                end else begin
                    io_bus.ack = a; io_bus.rdata = d;
                end
            end
        end
    endtask

    initial begin
        int          base_ram, base_io, base_ack;
        int          cyc_q [$];
        logic [31:0] dat_q [$];
        int          n0;
        logic [31:0] a;
        logic [31:0] corner [4];
        bus_tag_t    tg;
        exp_t        e;
        int          seq_ctr;
        bit          saw_unmap;
        logic [31:0] first_unmap;

        srst = 1'b1;
        cpud_bus.request = 1'b0; cpud_bus.addr = '0; cpud_bus.write = 1'b0;
        cpud_bus.byte_enable = '0; cpud_bus.wdata = '0;
        ram_bus.ack = 1'b0; ram_bus.rdata = '0;
        io_bus.ack  = 1'b0; io_bus.rdata  = '0;
        repeat (3) cyc();
        check("rst_cpud_ack",   cpud_bus.ack,   0);
        check("rst_cpud_rdata", cpud_bus.rdata, 0);
        check("rst_ram_req",    ram_bus.request, 0);
        check("rst_io_req",     io_bus.request,  0);
        check("rst_ram_addr",   ram_bus.addr,    0);
        check("rst_unmap_err",  unmapped_error,  0);
        check("rst_unmap_addr", unmapped_addr,   0);
        check("rst_proto_err",  protocol_error,  0);
        srst = 1'b0;
        cyc();

        // 1: RAM read, minimum latency
        req(32'h0000_0100, 1'b0, 4'hF, 32'h0);
        cyc();
        clr();
        check("t1_ram_req",  ram_bus.request, 1);
        check("t1_ram_addr", ram_bus.addr, 32'h0000_0100);
        check("t1_ram_wr",   ram_bus.write, 0);
        check("t1_io_req",   io_bus.request, 0);
        cyc();
        check("t1_no_early_ack", cpud_bus.ack, 0);
        ram_bus.ack = 1'b1; ram_bus.rdata = 32'h1234_5678;
        cyc();
        ram_bus.ack = 1'b0;
        check("t1_ack",   cpud_bus.ack, 1);
        check("t1_rdata", cpud_bus.rdata, 32'h1234_5678);
        cyc();
        check("t1_ack_pulse", cpud_bus.ack, 0);

        // 2: IO write
        base_ram = ram_req_cnt;
        req(32'hE000_0004, 1'b1, 4'b0011, 32'hCAFE_F00D);
        cyc();
        clr();
        check("t2_io_req",  io_bus.request, 1);
        check("t2_io_addr", io_bus.addr, 32'hE000_0004);
        check("t2_io_wr",   io_bus.write, 1);
        check("t2_io_be",   io_bus.byte_enable, 32'h3);
        check("t2_io_wdata", io_bus.wdata, 32'hCAFE_F00D);
        cyc();
        cyc();
        check("t2_no_early_ack", cpud_bus.ack, 0);
        io_bus.ack = 1'b1; io_bus.rdata = 32'h5555_AAAA;
        cyc();
        io_bus.ack = 1'b0;
        check("t2_ack", cpud_bus.ack, 1);
        check("t2_ram_never", 32'(ram_req_cnt - base_ram), 0);
        cyc();

        // 3: IO response overtakes RAM response
        req(32'h0000_0200, 1'b0, 4'hF, 32'h0);
        cyc();
        check("t3_ram_req", ram_bus.request, 1);
        req(32'hE000_0010, 1'b0, 4'hF, 32'h0);
        cyc();
        clr();
        check("t3_io_req", io_bus.request, 1);
        cyc();
        io_bus.ack = 1'b1; io_bus.rdata = 32'h1010_1010;
        for (int k = 4; k <= 12; k++) begin
            cyc();
            io_bus.ack = 1'b0;
            if (cpud_bus.ack) begin
                cyc_q.push_back(k);
                dat_q.push_back(cpud_bus.rdata);
            end
            ram_bus.ack   = (k == 8);
            ram_bus.rdata = 32'h2020_2020;
        end
        ram_bus.ack = 1'b0;
        check("t3_ack_count", 32'(cyc_q.size()), 2);
        if (cyc_q.size() == 2) begin
            check("t3_first_cyc",  32'(cyc_q[0]), 9);
            check("t3_first_data", dat_q[0], 32'h2020_2020);
            check("t3_second_cyc", 32'(cyc_q[1]), 10);
            check("t3_second_data", dat_q[1], 32'h1010_1010);
        end

        // 4: unmapped accesses
        base_ram = ram_req_cnt; base_io = io_req_cnt;
        req(32'h8000_0000, 1'b0, 4'hF, 32'h0);
        cyc();
        clr();
        check("t4_no_ack_n1", cpud_bus.ack, 0);
        cyc();
        check("t4_ack",        cpud_bus.ack, 1);
        check("t4_rdata",      cpud_bus.rdata, 32'h0);
        check("t4_unmap_err",  unmapped_error, 1);
        check("t4_unmap_addr", unmapped_addr, 32'h8000_0000);
        req(32'h9000_0000, 1'b1, 4'hF, 32'h1111_2222);
        cyc();
        clr();
        cyc();
        check("t4_ack2",        cpud_bus.ack, 1);
        check("t4_unmap_addr2", unmapped_addr, 32'h8000_0000);
        check("t4_no_tgt_req",  32'((ram_req_cnt - base_ram) + (io_req_cnt - base_io)), 0);
        check("t4_proto_clear", protocol_error, 0);

        // 5: overflow drops the fifth request
        base_ram = ram_req_cnt; base_ack = ack_cnt;
        for (int i = 0; i < 5; i++) begin
            req(32'h0000_1000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            cyc();
        end
        clr();
        cyc();
        check("t5_ram_reqs",   32'(ram_req_cnt - base_ram), 4);
        check("t5_proto_err",  protocol_error, 1);
        check("t5_no_acks",    32'(ack_cnt - base_ack), 0);
        dat_q.delete();
        for (int k = 0; k < 8; k++) begin
            ram_bus.ack   = (k < 4);
            ram_bus.rdata = 32'hA0 + 32'(k);
            cyc();
            if (cpud_bus.ack) dat_q.push_back(cpud_bus.rdata);
        end
        ram_bus.ack = 1'b0;
        check("t5_ack_count", 32'(dat_q.size()), 4);
        n0 = (dat_q.size() < 4) ? dat_q.size() : 4;
        for (int i = 0; i < n0; i++)
            check("t5_ack_data", dat_q[i], 32'hA0 + 32'(i));

        // 6: reset mid-flight, then stray acks
        for (int i = 0; i < 3; i++) begin
            req(32'h0000_2000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            cyc();
        end
        clr();
        cyc();
        srst = 1'b1;
        ram_bus.ack = 1'b1; ram_bus.rdata = 32'hDEAD_0000;
        cyc();
        ram_bus.ack = 1'b0;
        cyc();
        srst = 1'b0;
        cyc();
        check("t6_proto_after_rst", protocol_error, 0);
        check("t6_unmap_after_rst", unmapped_error, 0);
        check("t6_ack_after_rst",   cpud_bus.ack, 0);
        base_ack = ack_cnt;
        for (int k = 0; k < 3; k++) begin
            ram_bus.ack = 1'b1; ram_bus.rdata = 32'hBAD0 + 32'(k);
            cyc();
        end
        ram_bus.ack = 1'b0;
        repeat (3) cyc();
        check("t6_stray_no_ack", 32'(ack_cnt - base_ack), 0);
        check("t6_stray_proto",  protocol_error, 1);
        req(32'h0000_0300, 1'b0, 4'hF, 32'h0);
        cyc();
        clr();
        check("t6_new_ram_req", ram_bus.request, 1);
        cyc();
        ram_bus.ack = 1'b1; ram_bus.rdata = 32'h5A5A_5A5A;
        cyc();
        ram_bus.ack = 1'b0;
        check("t6_new_ack",   cpud_bus.ack, 1);
        check("t6_new_rdata", cpud_bus.rdata, 32'h5A5A_5A5A);

        // Random traffic
        srst = 1'b1;
        repeat (2) cyc();
        srst = 1'b0;
        cyc();
        last_due[0] = cyc_n; last_due[1] = cyc_n;
        auto_mode   = 1;
        seq_ctr     = 0;
        saw_unmap   = 0;
        first_unmap = '0;
        corner[0] = 32'h03FF_FFFC; corner[1] = 32'h0400_0000;
        corner[2] = 32'hDFFF_FFFC; corner[3] = 32'hF000_0000;
        for (int i = 0; i < 600; i++) begin
            if (outstanding < 4 && seq_ctr < 1024 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: a = {6'b0, 24'($urandom), 2'b00};
                    1: a = {4'hE, 26'($urandom), 2'b00};
                    2: a = {4'h8 | 4'($urandom_range(0, 3)), 28'($urandom)};
                    default: a = corner[$urandom_range(0, 3)];
                endcase
                tg = model_tag(a);
                e.tag = tg;
                e.wr  = 1'($urandom_range(0, 1));
                e.seq = seq_ctr;
                seq_addr[seq_ctr] = a;
                seq_wr[seq_ctr]   = e.wr;
                exp_q.push_back(e);
                if (tg == TAG_RAM) seq_q[0].push_back(seq_ctr);
                if (tg == TAG_IO)  seq_q[1].push_back(seq_ctr);
                if (tg == TAG_UNMAP && !saw_unmap) begin
                    saw_unmap   = 1;
                    first_unmap = a;
                end
                outstanding++;
                seq_ctr++;
                req(a, e.wr, 4'($urandom), $urandom);
            end else begin
                clr();
            end
            cyc();
        end
        clr();
        for (int k = 0; k < 300 && outstanding > 0; k++) cyc();
        check("rnd_drain_outstanding", 32'(outstanding), 0);
        check("rnd_proto_err",  protocol_error, 0);
        check("rnd_unmap_err",  unmapped_error, 32'(saw_unmap));
        check("rnd_unmap_addr", unmapped_addr, first_unmap);
        auto_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
